// File: rtl/bp_repair_sequencer_pkg.sv
// Shared types and sizes for the branch-predictor repair sequencer.
package bp_repair_sequencer_pkg;

    localparam int RA_W = 4;
    localparam int CP_W = 32;

    typedef struct packed {
        logic [RA_W-1:0] action;
        logic [CP_W-1:0] cp;
        logic [31:0]     vaddr;
        logic            take;
        logic [31:0]     dest;
    } rep_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rs_state_t;

endpackage

// File: rtl/bp_repair_sequencer_lowbit_sel.sv
// Lowest-set-bit picker: returns a one-hot of the lowest set bit of mask_i, zero if none.
module rs_lowbit_sel #(
    parameter int W = 4
) (
    input  logic [W-1:0] mask_i,
    output logic [W-1:0] sel_o
);

    logic found;

    // Scan from bit 0 upward and keep only the first hit.
    always_comb begin
        sel_o = '0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (mask_i[i] && !found) begin
                sel_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_repair_sequencer.sv
// Repair sequencer: arbitrates SBA/BSC repair requests and applies each accepted repair
// one predictor table per cycle over a shared write port.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no table write outstanding; active register may be loaded
//  ST_ISSUE | rep_valid_o high, rep_sel_o is the table being written
module bp_repair_sequencer
    import bp_repair_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            sba_valid_i,
    input  logic [RA_W-1:0] sba_action_i,
    input  logic [CP_W-1:0] sba_cp_i,
    input  logic [31:0]     sba_vaddr_i,
    input  logic            sba_take_i,
    input  logic [31:0]     sba_dest_i,
    input  logic            bsc_valid_i,
    input  logic [RA_W-1:0] bsc_action_i,
    input  logic [CP_W-1:0] bsc_cp_i,
    input  logic [31:0]     bsc_vaddr_i,
    input  logic            bsc_take_i,
    input  logic [31:0]     bsc_dest_i,
    output logic            bsc_ready_o,
    output logic            rep_valid_o,
    output logic [RA_W-1:0] rep_sel_o,
    output logic [CP_W-1:0] rep_cp_o,
    output logic [31:0]     rep_vaddr_o,
    output logic            rep_take_o,
    output logic [31:0]     rep_dest_o,
    input  logic            rep_ready_i,
    output logic            busy_o
);

    rs_state_t       state_q;
    rep_entry_t      act_q;
    logic [RA_W-1:0] mask_q;
    logic [RA_W-1:0] sel_q;
    rep_entry_t      bsc_q;
    logic            bsc_pend_q;

    rep_entry_t      sba_entry;
    rep_entry_t      bsc_entry;
    rep_entry_t      load_entry;
    logic            bsc_fire;
    logic            issue_ack;
    logic [RA_W-1:0] mask_left;
    logic            can_load;
    logic            load_en;
    logic            load_from_pend;
    logic            load_bypass;
    logic [RA_W-1:0] mask_d;
    logic [RA_W-1:0] sel_d;

    assign sba_entry = '{action: sba_action_i, cp: sba_cp_i, vaddr: sba_vaddr_i,
                         take: sba_take_i, dest: sba_dest_i};
    assign bsc_entry = '{action: bsc_action_i, cp: bsc_cp_i, vaddr: bsc_vaddr_i,
                         take: bsc_take_i, dest: bsc_dest_i};

    // Arbitration and next remaining-mask: SBA always wins, then the held BSC entry,
    // then a fresh BSC request bypassing the slot when the active register is free.
    always_comb begin
        bsc_fire       = bsc_valid_i && !bsc_pend_q && !sba_valid_i;
        issue_ack      = (state_q == ST_ISSUE) && rep_ready_i;
        mask_left      = mask_q & ~sel_q;
        can_load       = (state_q == ST_IDLE) || (issue_ack && (mask_left == '0));
        load_from_pend = !sba_valid_i && can_load && bsc_pend_q;
        load_bypass    = !sba_valid_i && can_load && bsc_fire;
        load_en        = sba_valid_i || load_from_pend || load_bypass;
        load_entry     = bsc_entry;
        if (sba_valid_i) begin
            load_entry = sba_entry;
        end else if (load_from_pend) begin
            load_entry = bsc_q;
        end
        mask_d = mask_q;
        if (load_en) begin
            mask_d = load_entry.action;
        end else if (issue_ack) begin
            mask_d = mask_left;
        end
    end

    rs_lowbit_sel #(.W(RA_W)) u_lowbit (
        .mask_i (mask_d),
        .sel_o  (sel_d)
    );

    // Sequencer FSM, BSC holding slot and active repair register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            act_q      <= '0;
            mask_q     <= '0;
            sel_q      <= '0;
            bsc_q      <= '0;
            bsc_pend_q <= 1'b0;
        end else begin
            if (sba_valid_i || load_from_pend) begin
                bsc_pend_q <= 1'b0;
            end else if (bsc_fire && !load_bypass) begin
                bsc_pend_q <= 1'b1;
                bsc_q      <= bsc_entry;
            end

            if (load_en) begin
                act_q   <= load_entry;
                mask_q  <= mask_d;
                sel_q   <= sel_d;
                state_q <= (mask_d != '0) ? ST_ISSUE : ST_IDLE;
            end else if (issue_ack) begin
                mask_q  <= mask_d;
                sel_q   <= sel_d;
                state_q <= (mask_d != '0) ? ST_ISSUE : ST_IDLE;
            end
        end
    end

    assign rep_valid_o = (state_q == ST_ISSUE);
    assign rep_sel_o   = sel_q;
    assign rep_cp_o    = act_q.cp;
    assign rep_vaddr_o = act_q.vaddr;
    assign rep_take_o  = act_q.take;
    assign rep_dest_o  = act_q.dest;
    assign bsc_ready_o = !bsc_pend_q;
    assign busy_o      = (state_q == ST_ISSUE) || bsc_pend_q;

endmodule

// File: tb/tb_bp_repair_sequencer.sv
// Testbench for bp_repair_sequencer: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_bp_repair_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sba_valid, bsc_valid, rep_ready;
    logic [3:0]  sba_action, bsc_action;
    logic [31:0] sba_cp, sba_vaddr, sba_dest, bsc_cp, bsc_vaddr, bsc_dest;
    logic        sba_take, bsc_take;
    logic        bsc_ready, rep_valid, rep_take, busy;
    logic [3:0]  rep_sel;
    logic [31:0] rep_cp, rep_vaddr, rep_dest;

    int n_pass  = 0;
    int n_total = 0;

    // status = {rep_valid, rep_sel, busy, bsc_ready}
    logic [6:0] status;
    assign status = {rep_valid, rep_sel, busy, bsc_ready};

    always #5 clk = ~clk;

    bp_repair_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .sba_valid_i  (sba_valid),
        .sba_action_i (sba_action),
        .sba_cp_i     (sba_cp),
        .sba_vaddr_i  (sba_vaddr),
        .sba_take_i   (sba_take),
        .sba_dest_i   (sba_dest),
        .bsc_valid_i  (bsc_valid),
        .bsc_action_i (bsc_action),
        .bsc_cp_i     (bsc_cp),
        .bsc_vaddr_i  (bsc_vaddr),
        .bsc_take_i   (bsc_take),
        .bsc_dest_i   (bsc_dest),
        .bsc_ready_o  (bsc_ready),
        .rep_valid_o  (rep_valid),
        .rep_sel_o    (rep_sel),
        .rep_cp_o     (rep_cp),
        .rep_vaddr_o  (rep_vaddr),
        .rep_take_o   (rep_take),
        .rep_dest_o   (rep_dest),
        .rep_ready_i  (rep_ready),
        .busy_o       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        sba_valid = 1'b0; sba_action = 4'h0; sba_cp = '0; sba_vaddr = '0; sba_take = 1'b0; sba_dest = '0;
        bsc_valid = 1'b0; bsc_action = 4'h0; bsc_cp = '0; bsc_vaddr = '0; bsc_take = 1'b0; bsc_dest = '0;
        rep_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        do_reset();
        n_total++;
        if (status !== 7'b0_0000_0_1) $display("FAIL reset_status got %b want %b", status, 7'b0_0000_0_1);
        else n_pass++;
        n_total++;
        if ({rep_cp, rep_vaddr, rep_take, rep_dest} !== 97'd0)
            $display("FAIL reset_payload got %h/%h/%b/%h want 0", rep_cp, rep_vaddr, rep_take, rep_dest);
        else n_pass++;
    endtask

    task automatic test_bsc_basic();
        quiet_inputs();
        bsc_valid = 1'b1; bsc_action = 4'b0101; bsc_vaddr = 32'h8000_0010; bsc_cp = 32'hC0DE_0001;
        bsc_take = 1'b1; bsc_dest = 32'h8000_0100;
        tick();
        bsc_valid = 1'b0;
        n_total++;
        if (status !== 7'b1_0001_1_1) $display("FAIL basic_n1 got %b want %b", status, 7'b1_0001_1_1);
        else n_pass++;
        n_total++;
        if ({rep_vaddr, rep_cp, rep_take, rep_dest} !== {32'h8000_0010, 32'hC0DE_0001, 1'b1, 32'h8000_0100})
            $display("FAIL basic_payload got %h/%h/%b/%h want 80000010/c0de0001/1/80000100",
                     rep_vaddr, rep_cp, rep_take, rep_dest);
        else n_pass++;
        tick();
        n_total++;
        if (status !== 7'b1_0100_1_1) $display("FAIL basic_n2 got %b want %b", status, 7'b1_0100_1_1);
        else n_pass++;
        tick();
        n_total++;
        if (status !== 7'b0_0000_0_1) $display("FAIL basic_n3 got %b want %b", status, 7'b0_0000_0_1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        quiet_inputs();
        rep_ready = 1'b0;
        bsc_valid = 1'b1; bsc_action = 4'b0101; bsc_vaddr = 32'h8000_0010; bsc_cp = 32'h1234_5678;
        bsc_dest = 32'hDEAD_BEE0;
        tick();
        bsc_valid = 1'b0; bsc_vaddr = 32'h0; bsc_cp = 32'h0; bsc_dest = 32'h0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (status !== 7'b1_0001_1_1 || rep_vaddr !== 32'h8000_0010 || rep_cp !== 32'h1234_5678)
                $display("FAIL hold_%0d got %b/%h/%h want %b/80000010/12345678", i, status, rep_vaddr, rep_cp,
                         7'b1_0001_1_1);
            else n_pass++;
            if (i == 2) rep_ready = 1'b1;
            tick();
        end
        n_total++;
        if (status !== 7'b1_0100_1_1) $display("FAIL hold_release got %b want %b", status, 7'b1_0100_1_1);
        else n_pass++;
        tick();
        n_total++;
        if (status !== 7'b0_0000_0_1) $display("FAIL hold_done got %b want %b", status, 7'b0_0000_0_1);
        else n_pass++;
    endtask

    task automatic test_sba_abort();
        quiet_inputs();
        bsc_valid = 1'b1; bsc_action = 4'b0111; bsc_vaddr = 32'h0000_1000;
        tick();
        bsc_valid = 1'b0;
        n_total++;
        if (status !== 7'b1_0001_1_1) $display("FAIL abort_pre got %b want %b", status, 7'b1_0001_1_1);
        else n_pass++;
        sba_valid = 1'b1; sba_action = 4'b1000; sba_vaddr = 32'h0000_2000; sba_dest = 32'h0000_3000;
        tick();
        sba_valid = 1'b0;
        n_total++;
        if (status !== 7'b1_1000_1_1 || rep_vaddr !== 32'h0000_2000 || rep_dest !== 32'h0000_3000)
            $display("FAIL abort_sba got %b/%h/%h want %b/00002000/00003000", status, rep_vaddr, rep_dest,
                     7'b1_1000_1_1);
        else n_pass++;
        tick();
        n_total++;
        if (status !== 7'b0_0000_0_1) $display("FAIL abort_done got %b want %b", status, 7'b0_0000_0_1);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        quiet_inputs();
        sba_valid = 1'b1; sba_action = 4'b0011; sba_vaddr = 32'hAAAA_0000;
        bsc_valid = 1'b1; bsc_action = 4'b0100; bsc_vaddr = 32'hBBBB_0000;
        tick();
        sba_valid = 1'b0; bsc_valid = 1'b0;
        n_total++;
        if (status !== 7'b1_0001_1_1 || rep_vaddr !== 32'hAAAA_0000)
            $display("FAIL same_first got %b/%h want %b/aaaa0000", status, rep_vaddr, 7'b1_0001_1_1);
        else n_pass++;
        tick();
        n_total++;
        if (status !== 7'b1_0010_1_1) $display("FAIL same_second got %b want %b", status, 7'b1_0010_1_1);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (status !== 7'b0_0000_0_1) $display("FAIL same_no_bsc_%0d got %b want %b", i, status, 7'b0_0000_0_1);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        quiet_inputs();
        rep_ready = 1'b0;
        bsc_valid = 1'b1; bsc_action = 4'b0001; bsc_vaddr = 32'h0000_0A00;
        tick();
        bsc_action = 4'b0010; bsc_vaddr = 32'h0000_0B00;
        tick();
        bsc_valid = 1'b0;
        n_total++;
        if (status !== 7'b1_0001_1_0 || rep_vaddr !== 32'h0000_0A00)
            $display("FAIL b2b_pend got %b/%h want %b/00000a00", status, rep_vaddr, 7'b1_0001_1_0);
        else n_pass++;
        rep_ready = 1'b1;
        tick();
        n_total++;
        if (status !== 7'b1_0010_1_1 || rep_vaddr !== 32'h0000_0B00)
            $display("FAIL b2b_next got %b/%h want %b/00000b00", status, rep_vaddr, 7'b1_0010_1_1);
        else n_pass++;
        tick();
        n_total++;
        if (status !== 7'b0_0000_0_1) $display("FAIL b2b_done got %b want %b", status, 7'b0_0000_0_1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        quiet_inputs();
        rep_ready = 1'b0;
        bsc_valid = 1'b1; bsc_action = 4'b0111;
        tick();
        bsc_action = 4'b0100;
        tick();
        bsc_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (status !== 7'b0_0000_0_1) $display("FAIL rst_mid got %b want %b", status, 7'b0_0000_0_1);
        else n_pass++;
        rep_ready = 1'b1;
        tick();
        n_total++;
        if (status !== 7'b0_0000_0_1) $display("FAIL rst_after got %b want %b", status, 7'b0_0000_0_1);
        else n_pass++;
        sba_valid = 1'b1; sba_action = 4'b0000;
        tick();
        sba_valid = 1'b0;
        n_total++;
        if (status !== 7'b0_0000_0_1) $display("FAIL zero_sba got %b want %b", status, 7'b0_0000_0_1);
        else n_pass++;
        bsc_valid = 1'b1; bsc_action = 4'b0000;
        tick();
        bsc_valid = 1'b0;
        n_total++;
        if (status !== 7'b0_0000_0_1) $display("FAIL zero_bsc got %b want %b", status, 7'b0_0000_0_1);
        else n_pass++;
    endtask

    // Reference model: remaining work is an integer bitmask, next table is its lowest set
    // bit (rem & -rem); a pending BSC request is a one-deep slot.
    int          m_rem;
    logic [31:0] m_cp, m_vaddr, m_dest;
    logic        m_take;
    logic        p_valid;
    int          p_act;
    logic [31:0] p_cp, p_vaddr, p_dest;
    logic        p_take;

    task automatic model_clear();
        m_rem = 0; m_cp = '0; m_vaddr = '0; m_dest = '0; m_take = 1'b0;
        p_valid = 1'b0; p_act = 0; p_cp = '0; p_vaddr = '0; p_dest = '0; p_take = 1'b0;
    endtask

    task automatic model_step();
        int left;
        bit free;
        bit accept;
        if (rst) begin
            model_clear();
            return;
        end
        left = (rep_ready && m_rem != 0) ? (m_rem & ~(m_rem & -m_rem)) : m_rem;
        free = (left == 0);
        accept = bsc_valid && !p_valid;
        if (sba_valid) begin
            m_rem = int'(sba_action); m_cp = sba_cp; m_vaddr = sba_vaddr; m_take = sba_take; m_dest = sba_dest;
            p_valid = 1'b0;
        end else if (free && p_valid) begin
            m_rem = p_act; m_cp = p_cp; m_vaddr = p_vaddr; m_take = p_take; m_dest = p_dest;
            p_valid = 1'b0;
        end else if (free && accept) begin
            m_rem = int'(bsc_action); m_cp = bsc_cp; m_vaddr = bsc_vaddr; m_take = bsc_take; m_dest = bsc_dest;
        end else begin
            m_rem = left;
            if (accept) begin
                p_valid = 1'b1; p_act = int'(bsc_action); p_cp = bsc_cp; p_vaddr = bsc_vaddr;
                p_take = bsc_take; p_dest = bsc_dest;
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_sel;
        quiet_inputs();
        do_reset();
        model_clear();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst        = ($urandom_range(0, 199) == 0);
            sba_valid  = ($urandom_range(0, 9) == 0);
            bsc_valid  = ($urandom_range(0, 2) == 0);
            rep_ready  = ($urandom_range(0, 9) < 7);
            sba_action = 4'($urandom); sba_cp = $urandom; sba_vaddr = $urandom;
            sba_take = 1'($urandom); sba_dest = $urandom;
            bsc_action = 4'($urandom); bsc_cp = $urandom; bsc_vaddr = $urandom;
            bsc_take = 1'($urandom); bsc_dest = $urandom;
            @(posedge clk);
            model_step();
            #1;
            exp_sel = 4'(m_rem & -m_rem);
            n_total++;
            if (status !== {m_rem != 0, exp_sel, (m_rem != 0) || p_valid, !p_valid})
                $display("FAIL rand_status cyc %0d got %b want %b", cyc, status,
                         {m_rem != 0, exp_sel, (m_rem != 0) || p_valid, !p_valid});
            else n_pass++;
            if (m_rem != 0) begin
                n_total++;
                if ({rep_cp, rep_vaddr, rep_take, rep_dest} !== {m_cp, m_vaddr, m_take, m_dest})
                    $display("FAIL rand_payload cyc %0d got %h/%h/%b/%h want %h/%h/%b/%h", cyc,
                             rep_cp, rep_vaddr, rep_take, rep_dest, m_cp, m_vaddr, m_take, m_dest);
                else n_pass++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet_inputs();
        test_reset();
        test_bsc_basic();
        test_backpressure();
        test_sba_abort();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
